// File: rtl/fifo_egress_packer.sv
// Egress packer: pulls words from a 1-cycle-latency FIFO into a 2-entry skid buffer
// and emits them as a ready/valid stream with packet-last tagging and ECC error counting.
module fifo_egress_packer #(
   parameter int DATA_WIDTH    = 32,
   parameter int LEN_WIDTH     = 8,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     hw_rst,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]    fifo_rd_data,
   input  logic                     ecc_err,
   input  logic [LEN_WIDTH-1:0]     pkt_len,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [DATA_WIDTH-1:0]    m_data,
   output logic                     m_last,
   output logic                     m_err,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  err;
      logic                  last;
   } beat_t;

   beat_t                ent_q [2];
   logic                 wr_ptr, rd_ptr;
   logic [1:0]           occ;
   logic                 inflight;
   logic [LEN_WIDTH-1:0] beat_idx, len_q;

   logic                 pop;
   logic [2:0]           fill;
   beat_t                head;
   logic [LEN_WIDTH-1:0] cur_len, eff_len;
   logic                 wr_last;

   assign head    = ent_q[rd_ptr];
   assign m_valid = !hw_rst && (occ != 2'd0);
   assign m_data  = head.data;
   assign m_err   = head.err;
   assign m_last  = head.last;
   assign pop     = m_valid && m_ready;

   // Slots committed after this cycle; a read is only issued if it still has a home.
   assign fill       = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
   assign fifo_rd_en = !hw_rst && !fifo_empty && (fill < 3'd2);

   // First beat of a packet uses the live pkt_len; later beats use the latched copy.
   assign cur_len = (beat_idx == '0) ? pkt_len : len_q;
   assign eff_len = (cur_len == '0) ? LEN_WIDTH'(1) : cur_len;
   assign wr_last = (beat_idx == eff_len - LEN_WIDTH'(1));

   always_ff @(posedge clk) begin
      if (hw_rst) begin
         occ      <= '0;
         inflight <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         beat_idx <= '0;
         len_q    <= '0;
         err_cnt  <= '0;
      end else begin
         inflight <= fifo_rd_en;
         occ      <= occ + {1'b0, inflight} - {1'b0, pop};
         if (inflight) begin
            wr_ptr   <= ~wr_ptr;
            beat_idx <= wr_last ? '0 : beat_idx + LEN_WIDTH'(1);
            if (beat_idx == '0)
               len_q <= pkt_len;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
            if (head.err && (err_cnt != '1))
               err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
         end
      end
   end

   // Datapath carries no reset; stale entries are unreachable once occ is cleared.
   always_ff @(posedge clk) begin
      if (inflight && !hw_rst)
         ent_q[wr_ptr] <= '{data: fifo_rd_data, err: ecc_err, last: wr_last};
   end

endmodule

// File: tb/tb_fifo_egress_packer.sv
// Directed bench for fifo_egress_packer: FIFO model with 1-cycle read latency,
// sink monitor with an independent occupancy model, and one task per scenario.
module tb_fifo_egress_packer;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int EW = 16;
   localparam int DEPTH = 16384;

   logic          clk = 1'b0;
   logic          hw_rst = 1'b1;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data = '0;
   logic          ecc_err = 1'b0;
   logic [LW-1:0] pkt_len = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          m_err;
   logic [EW-1:0] err_cnt;

   int checks = 0;
   int failures = 0;

   fifo_egress_packer #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .ERR_CNT_WIDTH(EW)) dut (
      .clk(clk), .hw_rst(hw_rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
      .fifo_rd_data(fifo_rd_data), .ecc_err(ecc_err), .pkt_len(pkt_len),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .m_err(m_err), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   // Upstream FIFO model: tb pushes at wr_idx, reads return data one cycle later.
   logic [DW-1:0] mem  [0:DEPTH-1];
   logic          merr [0:DEPTH-1];
   int            wr_idx = 0;
   int            rd_idx = 0;
   logic          hold_empty = 1'b0;

   assign fifo_empty = hold_empty || (rd_idx >= wr_idx);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_idx];
         ecc_err      <= merr[rd_idx];
         rd_idx       <= rd_idx + 1;
      end
   end

   // Sink monitor plus occupancy model built only from observed handshakes.
   logic [DW-1:0] rx_data [0:DEPTH-1];
   logic          rx_err  [0:DEPTH-1];
   logic          rx_last [0:DEPTH-1];
   int            rx_cyc  [0:DEPTH-1];
   int            rx_cnt = 0, rd_cnt = 0, cyc = 0;
   int            m_occ = 0, m_infl = 0, vld_bad = 0, ovf_bad = 0;
   int            mon_pop;

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (hw_rst) begin
         m_occ  = 0;
         m_infl = 0;
      end else begin
         if (m_valid !== (m_occ != 0)) vld_bad = vld_bad + 1;
         if (m_occ + m_infl > 2) ovf_bad = ovf_bad + 1;
         mon_pop = (m_valid === 1'b1 && m_ready === 1'b1) ? 1 : 0;
         if (mon_pop != 0) begin
            rx_data[rx_cnt] = m_data;
            rx_err[rx_cnt]  = m_err;
            rx_last[rx_cnt] = m_last;
            rx_cyc[rx_cnt]  = cyc;
            rx_cnt = rx_cnt + 1;
         end
         if (fifo_rd_en === 1'b1) rd_cnt = rd_cnt + 1;
         m_occ  = m_occ + m_infl - mon_pop;
         m_infl = (fifo_rd_en === 1'b1) ? 1 : 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] d, input logic e);
      mem[wr_idx]  = d;
      merr[wr_idx] = e;
      wr_idx = wr_idx + 1;
   endtask

   task automatic do_reset();
      hw_rst  = 1'b1;
      m_ready = 1'b0;
      tick();
      tick();
      hw_rst = 1'b0;
   endtask

   task automatic wait_beats(input int target, input int budget, output bit ok);
      int n;
      n = 0;
      while (rx_cnt < target && n < budget) begin
         tick();
         n++;
      end
      ok = (rx_cnt >= target);
   endtask

   task automatic test_reset();
      int  base;
      bit  ok;
      hw_rst = 1'b1;
      m_ready = 1'b1;
      pkt_len = 8'd1;
      push(32'h1111_0001, 1'b0);
      tick();
      tick();
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b want=0", fifo_rd_en); end
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
      checks++;
      if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
      tick();
      base = rx_cnt;
      hw_rst = 1'b0;
      wait_beats(base + 1, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL reset_first_beat timeout got=%0d want=%0d", rx_cnt - base, 1); end
      else begin
         checks++;
         if (rx_data[base] !== 32'h1111_0001 || rx_last[base] !== 1'b1) begin
            failures++; $display("FAIL reset_first_beat got=%h/%b want=11110001/1", rx_data[base], rx_last[base]);
         end
      end
   endtask

   task automatic test_basic();
      int  base;
      bit  ok;
      do_reset();
      pkt_len = 8'd4;
      m_ready = 1'b1;
      base = rx_cnt;
      for (int i = 0; i < 8; i++) push(32'hD000_0000 + i, 1'b0);
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b1 || m_valid !== 1'b0) begin
         failures++; $display("FAIL basic_latency_c0 rd_en/valid got=%b/%b want=1/0", fifo_rd_en, m_valid);
      end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_latency_c1 valid got=%b want=0", m_valid); end
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 32'hD000_0000) begin
         failures++; $display("FAIL basic_latency_c2 valid/data got=%b/%h want=1/d0000000", m_valid, m_data);
      end
      wait_beats(base + 8, 40, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL basic_timeout got=%0d want=8", rx_cnt - base); end
      else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_data[base+i] !== 32'hD000_0000 + i || rx_last[base+i] !== (i % 4 == 3)) begin
               failures++; $display("FAIL basic_beat%0d got=%h/%b want=%h/%b", i, rx_data[base+i], rx_last[base+i], 32'hD000_0000 + i, (i % 4 == 3));
            end
            if (i > 0) begin
               checks++;
               if (rx_cyc[base+i] - rx_cyc[base+i-1] != 1) begin
                  failures++; $display("FAIL basic_gap%0d got=%0d want=1", i, rx_cyc[base+i] - rx_cyc[base+i-1]);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int  base, rdb;
      bit  ok;
      do_reset();
      pkt_len = 8'd4;
      m_ready = 1'b0;
      base = rx_cnt;
      rdb = rd_cnt;
      for (int i = 0; i < 4; i++) push(32'hB000_0000 + i, 1'b0);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c >= 2) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 32'hB000_0000) begin
               failures++; $display("FAIL bp_hold_c%0d got=%b/%h want=1/b0000000", c, m_valid, m_data);
            end
         end
      end
      checks++;
      if (rd_cnt - rdb != 2) begin failures++; $display("FAIL bp_reads got=%0d want=2", rd_cnt - rdb); end
      tick();
      m_ready = 1'b1;
      wait_beats(base + 4, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_timeout got=%0d want=4", rx_cnt - base); end
      else begin
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_data[base+i] !== 32'hB000_0000 + i) begin
               failures++; $display("FAIL bp_beat%0d got=%h want=%h", i, rx_data[base+i], 32'hB000_0000 + i);
            end
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (rx_cyc[base+i] - rx_cyc[base+i-1] != 1) begin
               failures++; $display("FAIL bp_gap%0d got=%0d want=1", i, rx_cyc[base+i] - rx_cyc[base+i-1]);
            end
         end
      end
   endtask

   task automatic test_ecc();
      int  base;
      bit  ok;
      do_reset();
      pkt_len = 8'd6;
      m_ready = 1'b1;
      base = rx_cnt;
      for (int i = 0; i < 6; i++) push(32'hE000_0000 + i, (i == 1 || i == 4));
      wait_beats(base + 6, 30, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL ecc_timeout got=%0d want=6", rx_cnt - base); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_err[base+i] !== (i == 1 || i == 4) || rx_data[base+i] !== 32'hE000_0000 + i) begin
               failures++; $display("FAIL ecc_beat%0d err/data got=%b/%h want=%b/%h", i, rx_err[base+i], rx_data[base+i], (i == 1 || i == 4), 32'hE000_0000 + i);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (err_cnt !== 16'd2) begin failures++; $display("FAIL ecc_err_cnt got=%0d want=2", err_cnt); end
   endtask

   // Runs straight after test_ecc so err_cnt is non-zero going into the reset.
   task automatic test_reset_mid();
      int  base;
      bit  ok, hit;
      pkt_len = 8'd2;
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) push(32'hC000_0000 + i, 1'b0);
      hit = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
         tick();
         hit = (m_occ == 1 && m_infl == 1);
      end
      checks++;
      if (!hit) begin failures++; $display("FAIL rstmid_state got occ=%0d infl=%0d want 1/1", m_occ, m_infl); end
      hw_rst = 1'b1;
      tick();
      hw_rst = 1'b0;
      base = rx_cnt;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0 || err_cnt !== 16'd0) begin
         failures++; $display("FAIL rstmid_clear valid/err_cnt got=%b/%0d want=0/0", m_valid, err_cnt);
      end
      tick();
      m_ready = 1'b1;
      wait_beats(base + 2, 20, ok);
      repeat (4) tick();
      checks++;
      if (!ok || rx_cnt != base + 2) begin failures++; $display("FAIL rstmid_count got=%0d want=2", rx_cnt - base); end
      else begin
         checks++;
         if (rx_data[base] !== 32'hC000_0002 || rx_last[base] !== 1'b0 ||
             rx_data[base+1] !== 32'hC000_0003 || rx_last[base+1] !== 1'b1) begin
            failures++; $display("FAIL rstmid_beats got=%h/%b %h/%b want=c0000002/0 c0000003/1", rx_data[base], rx_last[base], rx_data[base+1], rx_last[base+1]);
         end
      end
   endtask

   task automatic test_len();
      int         base;
      bit         ok;
      logic [5:0] exp_last;
      do_reset();
      pkt_len = 8'd0;
      m_ready = 1'b1;
      base = rx_cnt;
      for (int i = 0; i < 3; i++) push(32'hF000_0000 + i, 1'b0);
      wait_beats(base + 3, 20, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL len0_timeout got=%0d want=3", rx_cnt - base); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_last[base+i] !== 1'b1) begin failures++; $display("FAIL len0_last%0d got=%b want=1", i, rx_last[base+i]); end
         end
      end
      m_ready = 1'b0;
      pkt_len = 8'd3;
      base = rx_cnt;
      for (int i = 0; i < 6; i++) push(32'hF100_0000 + i, 1'b0);
      repeat (5) tick();
      pkt_len = 8'd2;
      m_ready = 1'b1;
      exp_last = 6'b010100;
      wait_beats(base + 6, 30, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL lenchg_timeout got=%0d want=6", rx_cnt - base); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (rx_last[base+i] !== exp_last[i]) begin
               failures++; $display("FAIL lenchg_last%0d got=%b want=%b", i, rx_last[base+i], exp_last[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      int          base, n, exp_err, bad_d, bad_l, bad_e, vb0, ob0;
      int          first;
      logic [DW-1:0] w;
      logic        e;
      do_reset();
      pkt_len = 8'd5;
      base = rx_cnt;
      first = wr_idx;
      exp_err = 0;
      vb0 = vld_bad;
      ob0 = ovf_bad;
      for (int i = 0; i < 10000; i++) begin
         w = $urandom;
         e = ($urandom_range(7) == 0);
         if (e) exp_err++;
         push(w, e);
      end
      n = 0;
      while (rx_cnt < base + 10000 && n < 60000) begin
         m_ready    = ($urandom_range(3) != 0);
         hold_empty = ($urandom_range(3) == 0);
         tick();
         n++;
      end
      hold_empty = 1'b0;
      m_ready = 1'b1;
      repeat (4) tick();
      checks++;
      if (rx_cnt != base + 10000) begin failures++; $display("FAIL rand_count got=%0d want=10000", rx_cnt - base); end
      else begin
         bad_d = 0; bad_l = 0; bad_e = 0;
         for (int i = 0; i < 10000; i++) begin
            if (rx_data[base+i] !== mem[first+i]) bad_d++;
            if (rx_err[base+i] !== merr[first+i]) bad_e++;
            if (rx_last[base+i] !== (i % 5 == 4)) bad_l++;
         end
         checks++;
         if (bad_d != 0) begin failures++; $display("FAIL rand_data bad_beats got=%0d want=0", bad_d); end
         checks++;
         if (bad_e != 0) begin failures++; $display("FAIL rand_err_flag bad_beats got=%0d want=0", bad_e); end
         checks++;
         if (bad_l != 0) begin failures++; $display("FAIL rand_last bad_beats got=%0d want=0", bad_l); end
      end
      @(negedge clk);
      checks++;
      if (err_cnt !== EW'(exp_err)) begin failures++; $display("FAIL rand_err_cnt got=%0d want=%0d", err_cnt, exp_err); end
      checks++;
      if (ovf_bad != ob0) begin failures++; $display("FAIL rand_occupancy over2_cycles got=%0d want=0", ovf_bad - ob0); end
      checks++;
      if (vld_bad != vb0) begin failures++; $display("FAIL rand_valid_model bad_cycles got=%0d want=0", vld_bad - vb0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_ecc();
      test_reset_mid();
      test_len();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
